// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e : sequencer FSM states
//   Def*        : default values for the top-level parameters
//   cnt_width() : width of the shared cycle counter
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_e;

    localparam int unsigned DefLockStable = 1024;
    localparam int unsigned DefLockTimeout = 500000;
    localparam int unsigned DefRstPulse = 100;
    localparam int unsigned DefNRst = 3;
    localparam int unsigned DefReleaseGap = 16;
    localparam int unsigned DefMaxRetry = 7;

    // Counter must hold (limit - 1) for every limit passed in; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output (2 cycles latency)
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staggered reset-release sequencer on the free-running init clock.
// Pulses the PLL reset, waits for a debounced lock, then releases the downstream stage
// resets one at a time. Retries the PLL on lock timeout, gives up after MAX_RETRY retries,
// and re-asserts all stage resets on lock loss.
//   init_clk        : free-running clock
//   reset           : asynchronous active-high reset
//   pll_lock        : raw PLL lock (asynchronous)
//   pll_rst_req     : PLL reset request
//   rst_out         : per-stage active-high resets, bit 0 releases first
//   ready           : all stage resets released and lock held
//   fail            : sticky, retries exhausted
//   retry_count     : PLL retries since the last successful RUN
//   lock_loss_count : lock drops after release, saturating at 255
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = DefLockStable,
    parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
    parameter int unsigned RST_PULSE    = DefRstPulse,
    parameter int unsigned N_RST        = DefNRst,
    parameter int unsigned RELEASE_GAP  = DefReleaseGap,
    parameter int unsigned MAX_RETRY    = DefMaxRetry
) (
    input  logic             init_clk,
    input  logic             reset,
    input  logic             pll_lock,
    output logic             pll_rst_req,
    output logic [N_RST-1:0] rst_out,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       retry_count,
    output logic [7:0]       lock_loss_count
);

    // RELEASE counts one past the last release step before moving to RUN.
    localparam int unsigned CntW =
        cnt_width(LOCK_STABLE, LOCK_TIMEOUT, RST_PULSE, (N_RST - 1) * RELEASE_GAP + 2);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t PulseLast   = cnt_t'(RST_PULSE - 1);
    localparam cnt_t TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t StableLast  = cnt_t'(LOCK_STABLE - 1);
    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    logic lock_s;

    sync_2ff #(
        .Width(1)
    ) u_lock_sync (
        .clk(init_clk),
        .rst(reset),
        .d  (pll_lock),
        .q  (lock_s)
    );

    seq_state_e       state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [N_RST-1:0] rst_q, rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic [2:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        rst_d   = rst_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == PulseLast) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock wins over a coincident timeout.
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (retry_q == MaxRetry) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + 3'd1;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    // The PLL recovers by itself; only the stage resets are re-applied.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '1;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (state_q == RELEASE) begin
                    for (int unsigned i = 0; i < N_RST; i++) begin
                        if (cnt_q == cnt_t'(i * RELEASE_GAP)) rst_d[i] = 1'b0;
                    end
                    // Last stage was released on the previous edge.
                    if (rst_q == '0) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FAIL: begin
                cnt_d = cnt_q;
                rst_d = '1;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                rst_d   = '1;
            end
        endcase

        req_d   = (state_d == PLL_RST);
        ready_d = (state_d == RUN);
        fail_d  = (state_d == FAIL);
    end

    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            rst_q   <= '1;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            fail_q  <= fail_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign pll_rst_req     = req_q;
    assign rst_out         = rst_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (LOCK_TIMEOUT shortened to 1000).
// cyc counts rising edges since reset release; outputs are sampled on falling edges,
// and pll_lock driven on the falling edge before cycle N is first seen at edge N.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic       init_clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_rst_req;
    logic [2:0] rst_out;
    logic       ready;
    logic       fail;
    logic [2:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_reset_sequencer #(
        .LOCK_STABLE (1024),
        .LOCK_TIMEOUT(1000),
        .RST_PULSE   (100),
        .N_RST       (3),
        .RELEASE_GAP (16),
        .MAX_RETRY   (7)
    ) dut (
        .init_clk       (init_clk),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .pll_rst_req    (pll_rst_req),
        .rst_out        (rst_out),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 init_clk = ~init_clk;

    int cyc;
    always @(posedge init_clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        string       name;
        logic [16:0] exp;
    } exp_t;

    typedef struct {
        int   cyc;
        logic val;
    } lock_ev_t;

    typedef struct {
        int         off;
        logic [2:0] rst;
        logic       rdy;
    } rel_step_t;

    rel_step_t rel_tab[7];
    exp_t      exp_q[$];
    lock_ev_t  lk_q[$];
    int        n_tests = 0;
    int        n_fail = 0;

    logic [16:0] obs;
    assign obs = {pll_rst_req, rst_out, ready, fail, retry_count, lock_loss_count};

    function automatic logic [16:0] pack(logic req, logic [2:0] rst, logic rdy, logic fl,
                                         logic [2:0] retry, logic [7:0] loss);
        return {req, rst, rdy, fl, retry, loss};
    endfunction

    task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got req=%b rst=%b rdy=%b fail=%b retry=%0d loss=%0d want req=%b rst=%b rdy=%b fail=%b retry=%0d loss=%0d",
                     name, cyc, act[16], act[15:13], act[12], act[11], act[10:8], act[7:0],
                     exp[16], exp[15:13], exp[12], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    task automatic expect_at(int c, string name, logic req, logic [2:0] rst, logic rdy,
                             logic fl, logic [2:0] retry, logic [7:0] loss);
        exp_t e;
        e.cyc  = c;
        e.name = name;
        e.exp  = pack(req, rst, rdy, fl, retry, loss);
        exp_q.push_back(e);
    endtask

    task automatic lock_at(int c, logic v);
        lock_ev_t ev;
        ev.cyc = c;
        ev.val = v;
        lk_q.push_back(ev);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge init_clk);
    endtask

    task automatic drive_lock();
        lock_ev_t ev;
        while (lk_q.size() > 0) begin
            ev = lk_q.pop_front();
            wait_cyc(ev.cyc);
            pll_lock = ev.val;
        end
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_cyc(e.cyc);
            chk(e.name, obs, e.exp);
        end
    endtask

    // Release sequence with RELEASE entered at edge e (first n steps only).
    task automatic push_release(int e, logic [7:0] loss, int n);
        for (int i = 0; i < n; i++) begin
            expect_at(e + rel_tab[i].off, "release", 1'b0, rel_tab[i].rst, rel_tab[i].rdy,
                      1'b0, 3'd0, loss);
        end
    endtask

    task automatic run_scenario();
        fork
            drive_lock();
            drain();
        join
    endtask

    task automatic do_reset(logic lock_level);
        reset    = 1'b1;
        pll_lock = lock_level;
        repeat (3) @(negedge init_clk);
        chk("reset_state", obs, pack(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0));
        reset = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d: bench did not complete", cyc);
        $fatal(1);
    end

    initial begin
        rel_tab = '{'{0, 3'b111, 1'b0}, '{1, 3'b110, 1'b0}, '{16, 3'b110, 1'b0},
                    '{17, 3'b100, 1'b0}, '{32, 3'b100, 1'b0}, '{33, 3'b000, 1'b0},
                    '{34, 3'b000, 1'b1}};

        // Bring-up with lock at 200, one-cycle lock drop in RUN, reset mid-release.
        // Lock seen at 200 -> lock_s 201 -> STABLE 202 -> RELEASE 1226.
        // Drop seen at 1400 -> ready falls 1402 -> STABLE 1403 -> RELEASE 2427.
        do_reset(1'b0);
        expect_at(0, "post_reset", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        expect_at(99, "pulse_end", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        expect_at(100, "pulse_low", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        lock_at(199, 1'b1);
        lock_at(1399, 1'b0);
        lock_at(1400, 1'b1);
        push_release(1226, 8'd0, 7);
        expect_at(1401, "run_before_loss", 1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 8'd0);
        expect_at(1402, "loss_reassert", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0, 8'd1);
        push_release(2427, 8'd1, 4);
        run_scenario();
        wait_cyc(2450);
        chk("mid_release", obs, pack(1'b0, 3'b100, 1'b0, 1'b0, 3'd0, 8'd1));
        #1 reset = 1'b1;
        #1 chk("async_reset", obs, pack(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0));

        // Full bring-up after that reset with lock already high: STABLE 101, RELEASE 1125.
        do_reset(1'b1);
        expect_at(99, "pulse_end2", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        expect_at(100, "pulse_low2", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        push_release(1125, 8'd0, 7);
        run_scenario();

        // Lock glitch during STABLE: rise seen 710 -> STABLE restarts 712 -> RELEASE 1736.
        do_reset(1'b0);
        lock_at(199, 1'b1);
        lock_at(699, 1'b0);
        lock_at(709, 1'b1);
        expect_at(1226, "glitch_no_release", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        expect_at(1227, "glitch_still_held", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        push_release(1736, 8'd0, 7);
        run_scenario();

        // Lock never arrives: retry pulse k spans [1100k, 1100k+99], FAIL at 8800.
        do_reset(1'b0);
        for (int k = 1; k <= 7; k++) begin
            expect_at(1100 * k - 1, "retry_pre", 1'b0, 3'b111, 1'b0, 1'b0, 3'(k - 1), 8'd0);
            expect_at(1100 * k, "retry_rise", 1'b1, 3'b111, 1'b0, 1'b0, 3'(k), 8'd0);
            expect_at(1100 * k + 99, "retry_hold", 1'b1, 3'b111, 1'b0, 1'b0, 3'(k), 8'd0);
            expect_at(1100 * k + 100, "retry_fall", 1'b0, 3'b111, 1'b0, 1'b0, 3'(k), 8'd0);
        end
        expect_at(8799, "pre_fail", 1'b0, 3'b111, 1'b0, 1'b0, 3'd7, 8'd0);
        expect_at(8800, "fail_set", 1'b0, 3'b111, 1'b0, 1'b1, 3'd7, 8'd0);
        lock_at(9000, 1'b1);
        expect_at(9500, "fail_sticky", 1'b0, 3'b111, 1'b0, 1'b1, 3'd7, 8'd0);
        run_scenario();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
